// File: rtl/mux4_arb_pkg.sv
// Shared types and helpers for the 4-requester round-robin mux arbiter.
package mux4_arb_pkg;
  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {IDLE, GRANT} state_e;

  function automatic logic [NUM_REQ-1:0] onehot4(input logic [SEL_W-1:0] sel);
    onehot4 = 4'b0001 << sel;
  endfunction
endpackage

// File: rtl/rr_pick4.sv
// Rotating priority encoder: first set request bit at or after ptr, wrapping 3->0.
module rr_pick4
  import mux4_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [SEL_W-1:0]   ptr_i,
  output logic               any_o,
  output logic [SEL_W-1:0]   winner_o
);
  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [SEL_W-1:0]     off;

  always_comb begin
    req_dbl = {req_i, req_i};
    // rot[k] is the request k places after ptr
    rot     = req_dbl[ptr_i +: NUM_REQ];
    off     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) off = SEL_W'(k);
    end
    any_o    = |req_i;
    winner_o = ptr_i + off;
  end
endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin sequencer driving the shared 4:1 mux select with bounded grant hold.
// Optional MUX4_ARB_LOCK_EN adds a lock input that suppresses the hold timeout.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int DATA_W   = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        req,
  input  logic [DATA_W-1:0] d0,
  input  logic [DATA_W-1:0] d1,
  input  logic [DATA_W-1:0] d2,
  input  logic [DATA_W-1:0] d3,
  output logic [3:0]        gnt,
  output logic              s1,
  output logic              s0,
  output logic              busy,
  output logic [DATA_W-1:0] y
`ifdef MUX4_ARB_LOCK_EN
  ,
  input  logic              lock
`endif
);
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [7:0]       hold_q, hold_d;
  logic             any;
  logic [SEL_W-1:0] winner;
  logic             timeout;

  rr_pick4 u_pick (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .any_o    (any),
    .winner_o (winner)
  );

`ifdef MUX4_ARB_LOCK_EN
  assign timeout = (hold_q == HOLD_LAST) && !lock;
`else
  assign timeout = (hold_q == HOLD_LAST);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        // select is left untouched when nobody asks, so the mux never glitches
        if (any) begin
          state_d = GRANT;
          gnt_d   = onehot4(winner);
          sel_d   = winner;
          hold_d  = '0;
        end
      end
      GRANT: begin
        if (!req[sel_q] || timeout) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = sel_q + 2'd1;
          hold_d  = '0;
        end else begin
          hold_d = (hold_q == HOLD_LAST) ? hold_q : hold_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign gnt  = gnt_q;
  assign s1   = sel_q[1];
  assign s0   = sel_q[0];
  assign busy = (state_q == GRANT);

  always_comb begin
    y = '0;
    if (busy) begin
      case (sel_q)
        2'd0:    y = d0;
        2'd1:    y = d1;
        2'd2:    y = d2;
        default: y = d3;
      endcase
    end
  end
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: vector table on a MAX_HOLD=3 instance plus
// hand sequences for async reset, MAX_HOLD=1 rotation and the lock option.
module tb_mux4_rr_arbiter;
  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
  } vec_t;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic [3:0] y;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       lock;
  logic [3:0] d0 = 4'hA, d1 = 4'h5, d2 = 4'hC, d3 = 4'h3;
  logic [3:0] dv [4];

  logic [3:0] gnt_a, gnt_b;
  logic       s1_a, s0_a, busy_a, s1_b, s0_b, busy_b;
  logic [3:0] y_a, y_b;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t vecs[$];
  exp_t sb[$];

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.DATA_W(4), .MAX_HOLD(3)) dut (
    .clk(clk), .rst(rst), .req(req), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .gnt(gnt_a), .s1(s1_a), .s0(s0_a), .busy(busy_a), .y(y_a)
`ifdef MUX4_ARB_LOCK_EN
    , .lock(lock)
`endif
  );

  mux4_rr_arbiter #(.DATA_W(4), .MAX_HOLD(1)) u1 (
    .clk(clk), .rst(rst), .req(req), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .gnt(gnt_b), .s1(s1_b), .s0(s0_b), .busy(busy_b), .y(y_b)
`ifdef MUX4_ARB_LOCK_EN
    , .lock(lock)
`endif
  );

  function automatic exp_t mk(input logic [3:0] g, input logic [1:0] s, input logic b);
    exp_t e;
    e.gnt  = g;
    e.sel  = s;
    e.busy = b;
    e.y    = b ? dv[s] : 4'h0;
    return e;
  endfunction

  task automatic check(input string tag, input bit use_b, input exp_t e);
    logic [3:0] ag, ay;
    logic [1:0] as;
    logic       ab;
    ag = use_b ? gnt_b : gnt_a;
    as = use_b ? {s1_b, s0_b} : {s1_a, s0_a};
    ab = use_b ? busy_b : busy_a;
    ay = use_b ? y_b : y_a;
    n_cmp++;
    if (ag !== e.gnt) begin n_bad++; $display("FAIL %s gnt: got %b want %b", tag, ag, e.gnt); end
    n_cmp++;
    if (as !== e.sel) begin n_bad++; $display("FAIL %s sel: got %b want %b", tag, as, e.sel); end
    n_cmp++;
    if (ab !== e.busy) begin n_bad++; $display("FAIL %s busy: got %b want %b", tag, ab, e.busy); end
    n_cmp++;
    if (ay !== e.y) begin n_bad++; $display("FAIL %s y: got %h want %h", tag, ay, e.y); end
  endtask

  // Drive one cycle of stimulus, queue the expectation, compare after the edge.
  task automatic step(input string tag, input logic [3:0] r, input logic lk,
                      input exp_t e, input bit use_b);
    exp_t got;
    req  = r;
    lock = lk;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check(tag, use_b, got);
  endtask

  task automatic add(input logic [3:0] r, input logic [3:0] g, input logic [1:0] s, input logic b);
    vec_t v;
    v.req = r; v.gnt = g; v.sel = s; v.busy = b;
    vecs.push_back(v);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    req = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  initial begin
    dv[0] = 4'hA; dv[1] = 4'h5; dv[2] = 4'hC; dv[3] = 4'h3;
    // single requester 0, then voluntary drop; ptr moves to 1
    add(4'b0001, 4'b0001, 2'd0, 1'b1);
    add(4'b0000, 4'b0000, 2'd0, 1'b0);
    add(4'b0000, 4'b0000, 2'd0, 1'b0);
    add(4'b0011, 4'b0010, 2'd1, 1'b1);
    add(4'b0000, 4'b0000, 2'd1, 1'b0);
    // owner 1, non-owner changes ignored; next winner is 2
    add(4'b0010, 4'b0010, 2'd1, 1'b1);
    add(4'b1110, 4'b0010, 2'd1, 1'b1);
    add(4'b1100, 4'b0000, 2'd1, 1'b0);
    add(4'b1100, 4'b0100, 2'd2, 1'b1);
    add(4'b0000, 4'b0000, 2'd2, 1'b0);
    add(4'b0000, 4'b0000, 2'd2, 1'b0);
    // requester 3 alone: 3-cycle grant, bubble, re-grant
    for (int k = 0; k < 2; k++) begin
      add(4'b1000, 4'b1000, 2'd3, 1'b1);
      add(4'b1000, 4'b1000, 2'd3, 1'b1);
      add(4'b1000, 4'b1000, 2'd3, 1'b1);
      add(4'b1000, 4'b0000, 2'd3, 1'b0);
    end
    add(4'b0000, 4'b0000, 2'd3, 1'b0);
    // all request: rotation 0,1,2,3,0
    for (int k = 0; k < 4; k++) begin
      add(4'b1111, 4'b0001 << k, 2'(k), 1'b1);
      add(4'b1111, 4'b0001 << k, 2'(k), 1'b1);
      add(4'b1111, 4'b0001 << k, 2'(k), 1'b1);
      add(4'b1111, 4'b0000, 2'(k), 1'b0);
    end
    add(4'b1111, 4'b0001, 2'd0, 1'b1);
    add(4'b0000, 4'b0000, 2'd0, 1'b0);

    rst  = 1'b1;
    req  = 4'b0000;
    lock = 1'b0;
    #3;
    check("reset", 1'b0, mk(4'b0000, 2'd0, 1'b0));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++)
      step($sformatf("vec%0d", i), vecs[i].req, 1'b0,
           mk(vecs[i].gnt, vecs[i].sel, vecs[i].busy), 1'b0);

    // asynchronous reset in the middle of a grant to requester 2
    step("own2_a", 4'b0100, 1'b0, mk(4'b0100, 2'd2, 1'b1), 1'b0);
    step("own2_b", 4'b0100, 1'b0, mk(4'b0100, 2'd2, 1'b1), 1'b0);
    step("own2_c", 4'b0100, 1'b0, mk(4'b0100, 2'd2, 1'b1), 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_async", 1'b0, mk(4'b0000, 2'd0, 1'b0));
    @(posedge clk);
    #1;
    check("rst_held", 1'b0, mk(4'b0000, 2'd0, 1'b0));
    @(negedge clk);
    rst = 1'b0;
    step("ptr_reset", 4'b0011, 1'b0, mk(4'b0001, 2'd0, 1'b1), 1'b0);
    step("ptr_rel", 4'b0000, 1'b0, mk(4'b0000, 2'd0, 1'b0), 1'b0);

    // MAX_HOLD=1 instance: its ptr is 1 now; strict rotation, one grant per 2 cycles
    for (int k = 0; k < 4; k++) begin
      step($sformatf("mh1_g%0d", k), 4'b1111, 1'b0,
           mk(4'b0001 << ((k + 1) % 4), 2'((k + 1) % 4), 1'b1), 1'b1);
      step($sformatf("mh1_b%0d", k), 4'b1111, 1'b0,
           mk(4'b0000, 2'((k + 1) % 4), 1'b0), 1'b1);
    end

`ifdef MUX4_ARB_LOCK_EN
    pulse_reset();
    for (int k = 0; k < 20; k++)
      step($sformatf("lock%0d", k), 4'b0001, 1'b1, mk(4'b0001, 2'd0, 1'b1), 1'b0);
    step("lock_rel", 4'b0001, 1'b0, mk(4'b0000, 2'd0, 1'b0), 1'b0);
    step("lock_regrant", 4'b0001, 1'b0, mk(4'b0001, 2'd0, 1'b1), 1'b0);
`else
    pulse_reset();
    step("to_a", 4'b0001, 1'b0, mk(4'b0001, 2'd0, 1'b1), 1'b0);
    step("to_b", 4'b0001, 1'b0, mk(4'b0001, 2'd0, 1'b1), 1'b0);
    step("to_c", 4'b0001, 1'b0, mk(4'b0001, 2'd0, 1'b1), 1'b0);
    step("to_rel", 4'b0001, 1'b0, mk(4'b0000, 2'd0, 1'b0), 1'b0);
    step("to_regrant", 4'b0001, 1'b0, mk(4'b0001, 2'd0, 1'b1), 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Sequencing controller that shares one 4:1 multiplexer path between four requesters.
- Round-robin arbitration with bounded grant hold.
- Drives the 2-bit select (s1,s0) of the 4:1 mux and presents the selected data on y.
- Sits upstream of the existing gate-level 4x1 mux; replaces hand-driven select lines in testbenches and top levels.

Parameters:
- DATA_W, 1: width of each data input and of y (1 matches the existing mux).
- MAX_HOLD, 8: maximum consecutive GRANT cycles per owner, legal range 1..255.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  one clock; reset is asynchronous and active-high.
- req  in  4  request per requester; bit i = requester i.
- d0, d1, d2, d3  in  DATA_W each  requester data, routed as mux inputs d0..d3.
- gnt  out  4  one-hot grant, registered.
- s1  out  1  mux select MSB, registered.
- s0  out  1  mux select LSB, registered.
- busy  out  1  high in GRANT state.
- y  out  DATA_W  selected data: d[{s1,s0}] when busy, else 0 (combinational from registered select).
- lock  in  1  present only with MUX4_ARB_LOCK_EN.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; gnt=0; s1=0; s0=0; busy=0; y=0.
  - ptr=0 (requester 0 has highest priority); hold_cnt=0.
- IDLE:
  - If req != 0, select the first set bit searching ptr, ptr+1, ... modulo 4 (wrap 3->0).
  - Next edge: gnt=onehot(winner); {s1,s0}=winner; busy=1; hold_cnt=0; state=GRANT.
  - Request-to-grant latency is exactly 1 cycle.
- IDLE with req=0: no change; s1/s0 keep their last value so the mux select never glitches.
- GRANT: hold_cnt increments each cycle. Release on the edge where either:
  - req[owner]=0 (voluntary release), or
  - hold_cnt==MAX_HOLD-1 (timeout).
- On release:
  - gnt=0; busy=0; state=IDLE.
  - ptr=owner+1 mod 4; s1/s0 held.
  - Exactly one idle bubble cycle follows every grant.
- Timeout with req[owner] still high:
  - The owner loses priority via the ptr advance.
  - If it is the only requester, it is re-granted after the bubble.
- req changes of non-owners during GRANT are ignored until the next IDLE evaluation.
- Simultaneous release and new requests: new requests are evaluated in the following IDLE cycle, with ptr already advanced.
- Reset asserted mid-GRANT: immediate return to reset values; the in-flight transfer is abandoned.
- MAX_HOLD=1: every grant lasts exactly one cycle, giving a strict rotation at one grant per 2 cycles.
- hold_cnt width is 8 bits; it never exceeds MAX_HOLD-1.

Optional Feature:
- Macro MUX4_ARB_LOCK_EN.
- Defined:
  - lock input exists.
  - While in GRANT with lock=1, timeout is suppressed and hold_cnt saturates at MAX_HOLD-1.
  - Release occurs only via req[owner]=0, or via timeout on the first cycle lock=0 with hold_cnt at MAX_HOLD-1.
- Not defined: no lock port; timeout always enforced.

Decomposition:
- Shared package mux4_arb_pkg:
  - state enum {IDLE, GRANT}.
  - NUM_REQ=4, SEL_W=2.
  - Function onehot4(sel) returning the 4-bit one-hot grant.
- One natural sub-module: rr_pick4.
  - Combinational rotating priority encoder.
  - Inputs: req[3:0], ptr[1:0]. Outputs: any, winner[1:0].
  - Instantiated once in the FSM.

Test Plan:
- Reset mid-GRANT (owner 2, hold_cnt=3) -> same-cycle gnt=0, busy=0, s1=0, s0=0; after release, req=0001 -> owner 0 (ptr back at 0).
- req=0001 from reset, d0=1 -> gnt=0001, s1s0=00, y=1 one cycle later; drop req0 -> gnt=0 next edge, ptr=1.
- req=1111 held, MAX_HOLD=2 -> grant sequence 0,1,2,3,0 with each grant 2 cycles followed by a 1-cycle bubble; s1s0 = 00,01,10,11,00.
- req=1000 held alone, MAX_HOLD=3 -> GRANT 3 cycles, IDLE 1, re-grant to requester 3; ptr wraps to 0 each time.
- Owner 1 granted, req changes 0010->1110 mid-grant -> no change until req1 drops; next winner is 2, not 3.
- With MUX4_ARB_LOCK_EN, owner 0, lock=1 for 20 cycles, MAX_HOLD=4 -> gnt stays 0001 for 20 cycles; release on the edge lock falls.
